// File: rtl/max7219_arb_pkg.sv
// Shared definitions for the MAX7219 interface arbiter.
//   C_MAX7219_DATA_WIDTH : width of one word sent to the shared max7219_if
//   C_MAX_REQ            : largest supported requester count (owner index is 2 bits)
//   arb_state_t          : arbiter FSM state encoding
//   rr_index()           : wrap-around index helper used by the round-robin search
package max7219_arb_pkg;

    localparam int C_MAX7219_DATA_WIDTH = 16;
    localparam int C_MAX_REQ            = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_LOCKED    = 2'd3
    } arb_state_t;

    // (base + offset) mod nb_req, returned as a 2-bit requester index.
    function automatic logic [1:0] rr_index(input logic [1:0] base, input int offset, input int nb_req);
        return 2'((int'(base) + offset) % nb_req);
    endfunction

endpackage

// File: rtl/max7219_if_arbiter_if.sv
// Word-level link between the arbiter and one max7219_if serializer.
//   start   : one-cycle word start
//   en_load : word is the last of a frame (LOAD/CS is pulsed after it)
//   data    : 16-bit word, held stable until done
//   done    : one-cycle word-complete pulse from the serializer
// master = arbiter side, slave = serializer side.
interface max7219_if_arbiter_if;
    import max7219_arb_pkg::*;

    logic                            start;
    logic                            en_load;
    logic [C_MAX7219_DATA_WIDTH-1:0] data;
    logic                            done;

    modport master (output start, output en_load, output data, input done);
    modport slave  (input start, input en_load, input data, output done);

endinterface

// File: rtl/max7219_if_arbiter_rr.sv
// Round-robin selector for the arbiter.
//   req   : pending request vector (one bit per requester)
//   last  : index of the last granted requester
//   grant : first requesting index found searching from last+1 upward (wrapping)
//   valid : at least one request is present
// Purely combinational; the caller registers the result.
module rr_selector
    import max7219_arb_pkg::*;
#(
    parameter int G_NB_REQ = 2
) (
    input  logic [G_NB_REQ-1:0] req,
    input  logic [1:0]          last,
    output logic [1:0]          grant,
    output logic                valid
);

    // Zero-pad so a 2-bit index is always in range whatever G_NB_REQ is.
    logic [C_MAX_REQ-1:0] req_pad;
    assign req_pad = C_MAX_REQ'(req);

    // Walk from the farthest candidate back to last+1 so the nearest hit
    // overwrites the others and ends up as the grant.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = G_NB_REQ; i >= 1; i--) begin
            if (req_pad[rr_index(last, i, G_NB_REQ)]) begin
                grant = rr_index(last, i, G_NB_REQ);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/max7219_if_arbiter.sv
// Arbiter letting G_NB_REQ requesters share one max7219_if serializer.
// Each requester owns a one-word pending slot. Frames (sequences of words
// ending with en_load=1) are never interleaved: after a non-final word the
// owner keeps the link (LOCKED) until its final word, or until it idles for
// G_LOCK_TIMEOUT cycles, after which the lock is dropped.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   i_req_start/en_load/data         : per-requester word request (16 bits per slice)
//   o_req_done / o_req_err           : per-requester word-complete / overrun pulses
//   o_max7219_if_start/en_load/data  : word issued to the serializer
//   i_max7219_if_done                : serializer word complete
//   o_owner                          : current/last granted requester
//   o_busy                           : FSM not idle
//   o_lock_timeout                   : pulse when a lock is forcibly released
// All outputs come straight from registers.
module max7219_if_arbiter
    import max7219_arb_pkg::*;
#(
    parameter int G_NB_REQ       = 2,
    parameter int G_LOCK_TIMEOUT = 1024
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [G_NB_REQ-1:0]                      i_req_start,
    input  logic [G_NB_REQ-1:0]                      i_req_en_load,
    input  logic [C_MAX7219_DATA_WIDTH*G_NB_REQ-1:0] i_req_data,
    output logic [G_NB_REQ-1:0]                      o_req_done,
    output logic [G_NB_REQ-1:0]                      o_req_err,
    output logic                                     o_max7219_if_start,
    output logic                                     o_max7219_if_en_load,
    output logic [C_MAX7219_DATA_WIDTH-1:0]          o_max7219_if_data,
    input  logic                                     i_max7219_if_done,
    output logic [1:0]                               o_owner,
    output logic                                     o_busy,
    output logic                                     o_lock_timeout
);

    localparam int                 C_CNT_W     = $clog2(G_LOCK_TIMEOUT + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST  = C_CNT_W'(G_LOCK_TIMEOUT - 1);
    localparam logic [1:0]         C_OWNER_RST = 2'(G_NB_REQ - 1);

    // Slots are padded to C_MAX_REQ entries so the 2-bit owner can index them directly.
    logic [C_MAX_REQ-1:0]            pending;
    logic [C_MAX_REQ-1:0]            slot_en_load;
    logic [C_MAX7219_DATA_WIDTH-1:0] slot_data [C_MAX_REQ];
    logic [G_NB_REQ-1:0]             pending_clr;
    logic [G_NB_REQ-1:0]             err_vec;

    arb_state_t                      state_reg, state_next;
    logic [1:0]                      owner_reg, owner_next;
    logic [C_CNT_W-1:0]              cnt_reg, cnt_next;
    logic                            start_reg, start_next;
    logic                            en_load_reg, en_load_next;
    logic [C_MAX7219_DATA_WIDTH-1:0] data_reg, data_next;
    logic [G_NB_REQ-1:0]             done_reg;
    logic                            busy_reg;
    logic                            timeout_reg, timeout_next;

    logic                            done_accept;
    logic [1:0]                      rr_grant;
    logic                            rr_valid;

    // Only WAIT_DONE listens to the serializer.
    assign done_accept = (state_reg == ST_WAIT_DONE) && i_max7219_if_done;

    generate
        for (genvar gi = 0; gi < C_MAX_REQ; gi++) begin : g_slot
            if (gi < G_NB_REQ) begin : g_used
                logic                            pending_reg;
                logic                            slot_en_load_reg;
                logic [C_MAX7219_DATA_WIDTH-1:0] slot_data_reg;
                logic                            err_reg;

                assign pending_clr[gi] = done_accept && (owner_reg == 2'(gi));

                always_ff @(posedge clk) begin
                    if (rst) begin
                        pending_reg      <= 1'b0;
                        slot_en_load_reg <= 1'b0;
                        slot_data_reg    <= '0;
                        err_reg          <= 1'b0;
                    end else begin
                        // A start that finds the slot full is an overrun; the slot keeps its word.
                        err_reg <= i_req_start[gi] && pending_reg;
                        if (pending_clr[gi]) begin
                            pending_reg <= 1'b0;
                        end else if (i_req_start[gi] && !pending_reg) begin
                            pending_reg      <= 1'b1;
                            slot_en_load_reg <= i_req_en_load[gi];
                            slot_data_reg    <= i_req_data[C_MAX7219_DATA_WIDTH*gi +: C_MAX7219_DATA_WIDTH];
                        end
                    end
                end

                assign pending[gi]      = pending_reg;
                assign slot_en_load[gi] = slot_en_load_reg;
                assign slot_data[gi]    = slot_data_reg;
                assign err_vec[gi]      = err_reg;
            end else begin : g_unused
                assign pending[gi]      = 1'b0;
                assign slot_en_load[gi] = 1'b0;
                assign slot_data[gi]    = '0;
            end
        end
    endgenerate

    rr_selector #(
        .G_NB_REQ (G_NB_REQ)
    ) u_rr (
        .req   (pending[G_NB_REQ-1:0]),
        .last  (owner_reg),
        .grant (rr_grant),
        .valid (rr_valid)
    );

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        cnt_next     = cnt_reg;
        start_next   = 1'b0;
        en_load_next = en_load_reg;
        data_next    = data_reg;
        timeout_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (rr_valid) begin
                    owner_next   = rr_grant;
                    state_next   = ST_ISSUE;
                    start_next   = 1'b1;
                    en_load_next = slot_en_load[rr_grant];
                    data_next    = slot_data[rr_grant];
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_max7219_if_done) begin
                    cnt_next   = '0;
                    state_next = en_load_reg ? ST_IDLE : ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                // The owner's next word always beats the timeout on the same cycle.
                if (pending[owner_reg]) begin
                    state_next   = ST_ISSUE;
                    start_next   = 1'b1;
                    en_load_next = slot_en_load[owner_reg];
                    data_next    = slot_data[owner_reg];
                end else if (cnt_reg >= C_CNT_LAST) begin
                    // Owner is kept so the round-robin search starts after it.
                    timeout_next = 1'b1;
                    state_next   = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            owner_reg   <= C_OWNER_RST;
            cnt_reg     <= '0;
            start_reg   <= 1'b0;
            en_load_reg <= 1'b0;
            data_reg    <= '0;
            done_reg    <= '0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            cnt_reg     <= cnt_next;
            start_reg   <= start_next;
            en_load_reg <= en_load_next;
            data_reg    <= data_next;
            done_reg    <= pending_clr;
            busy_reg    <= (state_next != ST_IDLE);
            timeout_reg <= timeout_next;
        end
    end

    assign o_req_done           = done_reg;
    assign o_req_err            = err_vec;
    assign o_max7219_if_start   = start_reg;
    assign o_max7219_if_en_load = en_load_reg;
    assign o_max7219_if_data    = data_reg;
    assign o_owner              = owner_reg;
    assign o_busy               = busy_reg;
    assign o_lock_timeout       = timeout_reg;

endmodule

// File: tb/tb_max7219_if_arbiter.sv
// Self-checking bench for max7219_if_arbiter (3 requesters, lock timeout 16).
// A simple responder answers each issued word with done after a delay. A
// monitor logs every issued word and every done/err/timeout pulse; scenarios
// then compare the logs against expectations derived from the arbitration
// rules (word order per requester, frame contiguity, round-robin order,
// latencies, timeout distance).
module tb_max7219_if_arbiter;
    import max7219_arb_pkg::*;

    localparam int NB = 3;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] req_start   = '0;
    logic [NB-1:0] req_en_load = '0;
    logic [16*NB-1:0] req_data = '0;
    logic [NB-1:0] req_done, req_err;
    logic [1:0]    owner;
    logic          busy, lock_timeout;

    max7219_if_arbiter_if lk ();

    always #5 clk = ~clk;

    max7219_if_arbiter #(
        .G_NB_REQ       (NB),
        .G_LOCK_TIMEOUT (TO)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_req_start          (req_start),
        .i_req_en_load        (req_en_load),
        .i_req_data           (req_data),
        .o_req_done           (req_done),
        .o_req_err            (req_err),
        .o_max7219_if_start   (lk.start),
        .o_max7219_if_en_load (lk.en_load),
        .o_max7219_if_data    (lk.data),
        .i_max7219_if_done    (lk.done),
        .o_owner              (owner),
        .o_busy               (busy),
        .o_lock_timeout       (lock_timeout)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt [NB];
    int err_cnt  [NB];
    int to_cnt = 0;
    int to_cyc = 0;
    int done_cyc = 0;
    int t_start = 0;
    int iss_req [$];
    int iss_cyc [$];
    logic [15:0] iss_data [$];
    logic        iss_el [$];
    logic outstanding = 1'b0;
    bit   resp_rand = 1'b0;
    int   resp_delay = 10;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_issue(input string tag, input int idx, input int k, input logic [15:0] d, input logic el);
        if (idx < iss_req.size()) begin
            check_value({tag, "_req"}, iss_req[idx], k);
            check_value({tag, "_data"}, iss_data[idx], d);
            check_value({tag, "_en_load"}, iss_el[idx], el);
        end else begin
            check_value({tag, "_missing"}, iss_req.size(), idx + 1);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one line per transaction seen on the outputs.
    always @(negedge clk) begin
        if (rst) outstanding <= 1'b0;
        if (lk.start) begin
            iss_req.push_back(int'(owner));
            iss_data.push_back(lk.data);
            iss_el.push_back(lk.en_load);
            iss_cyc.push_back(cyc);
            outstanding <= 1'b1;
            $display("[%0d] issue req%0d data=%04h en_load=%0b", cyc, owner, lk.data, lk.en_load);
        end
        if (lk.done && outstanding && !rst) begin
            check_value("data_hold", lk.data, iss_data[$]);
            outstanding <= 1'b0;
        end
        for (int k = 0; k < NB; k++) begin
            if (req_done[k]) begin
                done_cnt[k] <= done_cnt[k] + 1;
                done_cyc <= cyc;
                if (iss_req.size() > 0) check_value("done_owner", k, iss_req[$]);
                $display("[%0d] done req%0d", cyc, k);
            end
            if (req_err[k]) begin
                err_cnt[k] <= err_cnt[k] + 1;
                $display("[%0d] overrun req%0d", cyc, k);
            end
        end
        if (lock_timeout) begin
            to_cnt <= to_cnt + 1;
            to_cyc <= cyc;
            $display("[%0d] lock timeout owner=%0d", cyc, owner);
        end
    end

    // Serializer stand-in: done one cycle wide, a fixed or random delay after start.
    initial begin
        lk.done = 1'b0;
        forever begin
            @(negedge clk);
            if (lk.start) begin
                int d;
                d = resp_rand ? int'($urandom_range(1, 6)) : resp_delay;
                repeat (d) @(posedge clk);
                #1 lk.done = 1'b1;
                @(posedge clk);
                #1 lk.done = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic send(input int k, input logic [15:0] d, input logic el);
        @(posedge clk);
        #1;
        req_start[k] = 1'b1;
        req_en_load[k] = el;
        req_data[16*k +: 16] = d;
        t_start = cyc;
        @(posedge clk);
        #1 req_start[k] = 1'b0;
    endtask

    task automatic send_pair(input int ka, input logic [15:0] da, input logic ea,
                             input int kb, input logic [15:0] db, input logic eb);
        @(posedge clk);
        #1;
        req_start[ka] = 1'b1; req_en_load[ka] = ea; req_data[16*ka +: 16] = da;
        req_start[kb] = 1'b1; req_en_load[kb] = eb; req_data[16*kb +: 16] = db;
        @(posedge clk);
        #1 req_start = '0;
    endtask

    task automatic wait_done(input int k, input int target, input string tag);
        for (int i = 0; i < 400 && done_cnt[k] < target; i++) @(posedge clk);
        check_value(tag, done_cnt[k], target);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int b, d0, d1, d2, tb0, eb0, viol, all_done;
        logic [15:0] exp_d [8];
        logic [15:0] rnd_data [NB][$];
        logic        rnd_el   [NB][$];
        int sent [NB], gap [NB], dbase [NB], ptr [NB];

        for (int k = 0; k < NB; k++) begin done_cnt[k] = 0; err_cnt[k] = 0; end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("rst_start", lk.start, 0);
        check_value("rst_en_load", lk.en_load, 0);
        check_value("rst_data", lk.data, 0);
        check_value("rst_busy", busy, 0);
        check_value("rst_owner", owner, NB - 1);
        check_value("rst_done", req_done, 0);
        check_value("rst_err", req_err, 0);
        check_value("rst_timeout", lock_timeout, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single 8-word frame on requester 0
        b = iss_req.size();
        d0 = done_cnt[0];
        for (int w = 0; w < 8; w++) begin
            exp_d[w] = (w == 7) ? 16'h0F01 : 16'((w + 1) * 256 + w);
            send(0, exp_d[w], w == 7);
            if (w == 0) tb0 = t_start;
            wait_done(0, d0 + w + 1, "frame8_done");
        end
        check_value("frame8_issues", iss_req.size() - b, 8);
        if (iss_cyc.size() > b) check_value("start_latency", iss_cyc[b] - tb0, 2);
        for (int w = 0; w < 8; w++) check_issue("frame8", b + w, 0, exp_d[w], w == 7);
        @(negedge clk);
        check_value("frame8_busy_low", busy, 0);
        check_value("frame8_no_timeout", to_cnt, 0);

        // Simultaneous starts after reset: requester 0 first, frames not interleaved
        do_reset();
        b = iss_req.size(); d0 = done_cnt[0]; d1 = done_cnt[1];
        send_pair(0, 16'h1100, 1'b0, 1, 16'h2200, 1'b0);
        wait_done(0, d0 + 1, "pair_r0w0");
        send(0, 16'h1101, 1'b1);
        wait_done(0, d0 + 2, "pair_r0w1");
        wait_done(1, d1 + 1, "pair_r1w0");
        send(1, 16'h2201, 1'b1);
        wait_done(1, d1 + 2, "pair_r1w1");
        check_issue("pair0", b,     0, 16'h1100, 1'b0);
        check_issue("pair1", b + 1, 0, 16'h1101, 1'b1);
        check_issue("pair2", b + 2, 1, 16'h2200, 1'b0);
        check_issue("pair3", b + 3, 1, 16'h2201, 1'b1);

        // Round-robin continues after owner 1: requester 2 before requester 0
        b = iss_req.size(); d0 = done_cnt[0]; d2 = done_cnt[2];
        send_pair(0, 16'h3300, 1'b1, 2, 16'h4400, 1'b1);
        wait_done(0, d0 + 1, "rr_r0");
        wait_done(2, d2 + 1, "rr_r2");
        check_issue("rr0", b,     2, 16'h4400, 1'b1);
        check_issue("rr1", b + 1, 0, 16'h3300, 1'b1);

        // Requester 1 arrives while requester 0 holds the lock
        b = iss_req.size(); d0 = done_cnt[0]; d1 = done_cnt[1];
        send(0, 16'h5500, 1'b0);
        wait_done(0, d0 + 1, "lock_r0w0");
        send(1, 16'hA55A, 1'b1);
        repeat (6) @(posedge clk);
        check_value("lock_no_foreign_issue", iss_req.size() - b, 1);
        send(0, 16'h5501, 1'b1);
        wait_done(0, d0 + 2, "lock_r0w1");
        wait_done(1, d1 + 1, "lock_r1");
        check_issue("lock0", b,     0, 16'h5500, 1'b0);
        check_issue("lock1", b + 1, 0, 16'h5501, 1'b1);
        check_issue("lock2", b + 2, 1, 16'hA55A, 1'b1);

        // Open frame is released after TO idle cycles; waiting requester 1 follows
        do_reset();
        b = iss_req.size(); d0 = done_cnt[0]; d1 = done_cnt[1]; tb0 = to_cnt;
        send(0, 16'h6600, 1'b0);
        wait_done(0, d0 + 1, "to_r0");
        d2 = done_cyc;
        send(1, 16'hBEEF, 1'b1);
        for (int i = 0; i < 100 && to_cnt == tb0; i++) @(posedge clk);
        check_value("to_pulse_count", to_cnt - tb0, 1);
        check_value("to_distance", to_cyc - d2, TO);
        wait_done(1, d1 + 1, "to_r1");
        check_issue("to_next", b + 1, 1, 16'hBEEF, 1'b1);
        check_value("to_owner", owner, 1);

        // Overrun: second start while pending is dropped and flagged once
        do_reset();
        b = iss_req.size(); d0 = done_cnt[0]; eb0 = err_cnt[0];
        send(0, 16'h1234, 1'b1);
        send(0, 16'h5678, 1'b1);
        wait_done(0, d0 + 1, "ovr_done");
        repeat (20) @(posedge clk);
        check_value("ovr_err_pulses", err_cnt[0] - eb0, 1);
        check_value("ovr_issue_count", iss_req.size() - b, 1);
        check_issue("ovr_word", b, 0, 16'h1234, 1'b1);

        // Reset while waiting for done
        resp_delay = 20;
        b = iss_req.size(); d0 = done_cnt[0];
        send(0, 16'h7700, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_value("mid_rst_start", lk.start, 0);
        check_value("mid_rst_data", lk.data, 0);
        check_value("mid_rst_busy", busy, 0);
        check_value("mid_rst_owner", owner, NB - 1);
        check_value("mid_rst_done", req_done, 0);
        repeat (30) @(posedge clk);
        check_value("mid_rst_no_done", done_cnt[0] - d0, 0);
        check_value("mid_rst_issue_count", iss_req.size() - b, 1);
        check_value("mid_rst_idle", busy, 0);
        resp_delay = 10;

        // Randomized frames on all requesters, random serializer latency
        do_reset();
        resp_rand = 1'b1;
        b = iss_req.size(); tb0 = to_cnt;
        for (int k = 0; k < NB; k++) begin
            for (int f = 0; f < 3; f++) begin
                int n;
                n = int'($urandom_range(1, 4));
                for (int w = 0; w < n; w++) begin
                    rnd_data[k].push_back(16'($urandom));
                    rnd_el[k].push_back(w == n - 1);
                end
            end
            sent[k] = 0; gap[k] = 0; ptr[k] = 0; dbase[k] = done_cnt[k];
        end
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk);
            #1;
            req_start = '0;
            all_done = 1;
            for (int k = 0; k < NB; k++) begin
                if (sent[k] < rnd_data[k].size() || done_cnt[k] - dbase[k] < rnd_data[k].size()) all_done = 0;
                if (sent[k] < rnd_data[k].size() && done_cnt[k] - dbase[k] == sent[k]) begin
                    if (gap[k] > 0) begin
                        gap[k]--;
                    end else begin
                        req_start[k] = 1'b1;
                        req_data[16*k +: 16] = rnd_data[k][sent[k]];
                        req_en_load[k] = rnd_el[k][sent[k]];
                        sent[k]++;
                        gap[k] = int'($urandom_range(0, 2));
                    end
                end
            end
            if (all_done != 0) break;
        end
        req_start = '0;
        for (int k = 0; k < NB; k++)
            check_value($sformatf("rnd_done_r%0d", k), done_cnt[k] - dbase[k], rnd_data[k].size());
        viol = 0;
        for (int i = b; i < iss_req.size(); i++) begin
            int k;
            k = iss_req[i];
            if (i > b && iss_el[i-1] == 1'b0 && iss_req[i-1] != k) viol++;
            if (k < NB && ptr[k] < rnd_data[k].size()) begin
                check_value($sformatf("rnd_data_r%0d_w%0d", k, ptr[k]), iss_data[i], rnd_data[k][ptr[k]]);
                check_value($sformatf("rnd_el_r%0d_w%0d", k, ptr[k]), iss_el[i], rnd_el[k][ptr[k]]);
                ptr[k]++;
            end else begin
                check_value("rnd_extra_issue", k, 32'hFFFF_FFFF);
            end
        end
        check_value("rnd_frame_interleave", viol, 0);
        check_value("rnd_no_timeout", to_cnt - tb0, 0);
        resp_rand = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
